string_escape_decoder: RTL
==========================

// Module: string_escape_decoder
// PURPOSE
//  Streaming decoder for Verilog-style escaped string literals: consumes one source char/cycle, emits decoded bytes.
//  Inverse of the string-formatting path; it turns "\\n", "\\t", "\\\\", "\\\"" and octal "\\ddd" back into raw bytes.
//  Sits between a char source (UART/ROM) and the display/compare logic; valid/ready on both sides.
// PARAMETERS
//  CNT_W       8  width of saturating error counter err_cnt
//  ERR_STICKY  0  1: err_flag holds until rst; 0: err_flag is a 1-cycle pulse per bad escape
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      in_data/in_last valid
//  in_ready   out  1      decoder accepts char this cycle
//  in_data    in   8      source ASCII char
//  in_last    in   1      final char of string
//  out_valid  out  1      out_data valid
//  out_ready  in   1      sink accepts byte
//  out_data   out  8      decoded byte
//  out_last   out  1      final decoded byte of string
//  err_flag   out  1      malformed escape seen (see ERR_STICKY)
//  err_cnt    out  CNT_W  malformed escapes since rst, saturates at all-ones
// BEHAVIOUR
//  Reset: all outputs 0, state NORM, octal accumulator 0, in_ready 0 during rst cycle.
//  Handshake: transfer on valid&&ready; out_valid held with data stable until out_ready; 1-entry registered output.
//  in_ready = !rst && (!out_valid || out_ready) && !hold; latency input->output 1 cycle.
//  FSM: NORM, ESC, OCT1, OCT2 (digits seen = 1, 2).
//   NORM: '\\'(0x5C) -> ESC, no output; other char -> emit char.
//   ESC: 'n'->0x0A, 't'->0x09, '\\'->0x5C, '"'->0x22 -> emit, NORM.
//        '0'..'7' -> acc=digit, OCT1 (macro only); any other char c -> emit c, err, NORM.
//   OCT1/OCT2: octal digit -> acc=acc*8+digit; from OCT2 emit acc[7:0], NORM (3-digit max).
//        non-octal char -> emit acc[7:0], hold=1: char NOT consumed (in_ready low), reprocessed next cycle in NORM.
//  Octal overflow: acc > 255 (e.g. \\777) -> emit acc[7:0], err.
//  in_last in NORM/OCT*: output byte carries out_last=1. Octal pending + in_last on digit -> value w/ out_last.
//  in_last on the '\\' itself (dangling escape): emit 0x5C w/ out_last=1, err.
//  After last byte: state NORM, acc 0. Back-to-back strings allowed, no gap cycle.
//  err: asserted with the output byte of the bad escape (same cycle out_valid rises); err_cnt +1 same edge.
//  rst mid-string: partial escape discarded, no output, counters cleared.
// CONFIGURATION
//  OCTAL_ESC_EN defined: \\d, \\dd, \\ddd octal decode as above.
//  Undefined: ESC + digit treated as unknown escape -> emit digit char literally, err; OCT1/OCT2 unreachable.
// STRUCTURE
//  Package string_esc_pkg: state enum typedef (NORM/ESC/OCT1/OCT2), char constants
//   CH_BSLASH=8'h5C, CH_QUOTE=8'h22, CH_N=8'h6E, CH_T=8'h74, CH_LF=8'h0A, CH_TAB=8'h09.
//  Sub-module esc_out_stage: 1-entry output register (data/last/valid) w/ ready handling; FSM+acc in top.
// TESTING
//  "Out = in1 + in2" w/ last on '2', out_ready=1 -> same 15 bytes, out_last on 0x32, err 0, 1 byte/cycle.
//  "a\\nb\\t\\\\" -> 0x61,0x0A,0x62,0x09,0x5C; out_last on 0x5C; err_cnt 0.
//  (OCTAL_ESC_EN) "bell\\007" -> 'b','e','l','l',0x07; "\\101B" -> 0x41,0x42; "\\7x" -> 0x07 then 'x' (1 hold cycle).
//  "\\777" -> 0xFF, err_cnt=1; "\\q" -> 'q', err; "ab\\" w/ last -> 'a','b',0x5C+last, err_cnt +1.
//  out_ready toggled 1010... on 20-char string -> no loss/dup, out_data stable while stalled, in_ready tracks.
//  rst asserted after "\\1" consumed -> outputs 0 next cycle; "X" after rst -> 'X' only; err_cnt saturates at 255.

Source files
------------

// File: rtl/string_esc_pkg.sv
// Shared types and character constants for the escaped-string decoder.
package string_esc_pkg;

  typedef enum logic [1:0] {
    NORM = 2'd0,
    ESC  = 2'd1,
    OCT1 = 2'd2,
    OCT2 = 2'd3
  } esc_state_t;

  localparam logic [7:0] CH_BSLASH = 8'h5C;
  localparam logic [7:0] CH_QUOTE  = 8'h22;
  localparam logic [7:0] CH_N      = 8'h6E;
  localparam logic [7:0] CH_T      = 8'h74;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_TAB    = 8'h09;

  // '0'..'7' are 0x30..0x37
  function automatic logic is_octal(input logic [7:0] c);
    return c[7:3] == 5'b00110;
  endfunction

endpackage

// File: rtl/esc_out_stage.sv
// One-entry registered output slot; loads when empty or draining this cycle.
// Data and last stay stable while out_valid is high and out_ready is low.
module esc_out_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       can_load,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last
);

  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_last  <= load_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/string_escape_decoder.sv
// Streaming decoder of escaped string literals, one char in / one byte out, 1-cycle latency,
// stalls input while the output slot is full. Octal escapes only when OCTAL_ESC_EN is defined.
module string_escape_decoder
  import string_esc_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter bit ERR_STICKY = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt
);

  esc_state_t state_q, state_d;
  logic [5:0] acc_q, acc_d;   // at most two octal digits are ever held
  logic [8:0] acc_next;
  logic       stage_can, can_load, go, hold;
  logic       emit, emit_last, bad;
  logic [7:0] emit_data;

  assign can_load = !rst && stage_can;
  assign go       = in_valid && can_load;
  assign in_ready = can_load && !hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NORM;
      acc_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    emit      = 1'b0;
    emit_data = in_data;
    emit_last = in_last;
    bad       = 1'b0;
    hold      = 1'b0;
    acc_next  = {acc_q, 3'b000} + {6'd0, in_data[2:0]};
    if (in_valid) begin
      unique case (state_q)
        NORM: begin
          if (in_data == CH_BSLASH && !in_last) begin
            state_d = ESC;
          end else begin
            // a trailing backslash is passed through but flagged
            emit = 1'b1;
            bad  = (in_data == CH_BSLASH);
          end
        end
        ESC: begin
          state_d = NORM;
          emit    = 1'b1;
          if (in_data == CH_N) begin
            emit_data = CH_LF;
          end else if (in_data == CH_T) begin
            emit_data = CH_TAB;
          end else if (in_data == CH_BSLASH || in_data == CH_QUOTE) begin
            emit_data = in_data;
`ifdef OCTAL_ESC_EN
          end else if (is_octal(in_data)) begin
            emit_data = {5'd0, in_data[2:0]};
            if (!in_last) begin
              emit    = 1'b0;
              state_d = OCT1;
              acc_d   = {3'd0, in_data[2:0]};
            end
`endif
          end else begin
            bad = 1'b1;
          end
        end
        OCT1, OCT2: begin
          state_d = NORM;
          acc_d   = 6'd0;
          emit    = 1'b1;
          if (!is_octal(in_data)) begin
            // flush the pending value; the char is replayed from NORM next cycle
            hold      = 1'b1;
            emit_data = {2'b00, acc_q};
            emit_last = 1'b0;
          end else begin
            emit_data = acc_next[7:0];
            if (state_q == OCT2) begin
              bad = acc_next[8];
            end else if (!in_last) begin
              emit    = 1'b0;
              state_d = OCT2;
              acc_d   = acc_next[5:0];
            end
          end
        end
        default: state_d = NORM;
      endcase
    end
    if (!go) begin
      state_d = state_q;
      acc_d   = acc_q;
      emit    = 1'b0;
      bad     = 1'b0;
    end
  end

  esc_out_stage u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (emit),
    .load_data (emit_data),
    .load_last (emit_last),
    .can_load  (stage_can),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end else begin
      err_flag <= ERR_STICKY ? (err_flag || bad) : bad;
      if (bad && (err_cnt != {CNT_W{1'b1}}))
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule
